// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU control codes, decoded entry and buffer states.
package rv32i_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_SLL  = 4'h2;
    localparam logic [3:0] ALU_SLT  = 4'h3;
    localparam logic [3:0] ALU_SLTU = 4'h4;
    localparam logic [3:0] ALU_XOR  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_OR   = 4'h8;
    localparam logic [3:0] ALU_AND  = 4'h9;
    localparam logic [3:0] ALU_LB   = 4'hA;
    localparam logic [3:0] ALU_LH   = 4'hB;
    localparam logic [3:0] ALU_LBU  = 4'hC;
    localparam logic [3:0] ALU_LHU  = 4'hD;

    // One decoded instruction as it sits in the skid buffer
    typedef struct packed {
        logic [3:0]  control;
        logic [31:0] imm;
        logic        alu_src_imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        illegal;
    } dec_entry_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    // Sign-extended I-type immediate
    function automatic logic [31:0] imm_i(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

    // Sign-extended S-type immediate
    function automatic logic [31:0] imm_s(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:25], instr[11:7]};
    endfunction

endpackage

// File: rtl/rv32i_decode_comb.sv
// Pure combinational RV32I instruction to decoded-entry translation.
module rv32i_decode_comb
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    output dec_entry_t  entry
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Start from an illegal entry with raw register fields, then fill in recognised encodings
    always_comb begin
        entry         = '0;
        entry.rs1     = instr[19:15];
        entry.rs2     = instr[24:20];
        entry.rd      = instr[11:7];
        entry.illegal = 1'b1;
        unique case (opcode)
            OP_R: begin
                if (funct7 == F7_BASE) begin
                    entry.illegal = 1'b0;
                    unique case (funct3)
                        3'b000: entry.control = ALU_ADD;
                        3'b001: entry.control = ALU_SLL;
                        3'b010: entry.control = ALU_SLT;
                        3'b011: entry.control = ALU_SLTU;
                        3'b100: entry.control = ALU_XOR;
                        3'b101: entry.control = ALU_SRL;
                        3'b110: entry.control = ALU_OR;
                        3'b111: entry.control = ALU_AND;
                        default: entry.control = ALU_ADD;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    entry.illegal = 1'b0;
                    entry.control = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    entry.illegal = 1'b0;
                    entry.control = ALU_SRA;
                end
                entry.reg_write = !entry.illegal;
            end
            OP_I: begin
                entry.illegal = 1'b0;
                unique case (funct3)
                    3'b000: entry.control = ALU_ADD;
                    3'b010: entry.control = ALU_SLT;
                    3'b011: entry.control = ALU_SLTU;
                    3'b100: entry.control = ALU_XOR;
                    3'b110: entry.control = ALU_OR;
                    3'b111: entry.control = ALU_AND;
                    3'b001: begin
                        entry.control = ALU_SLL;
                        entry.illegal = (funct7 != F7_BASE);
                    end
                    3'b101: begin
                        if (funct7 == F7_BASE) begin
                            entry.control = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            entry.control = ALU_SRA;
                        end else begin
                            entry.illegal = 1'b1;
                        end
                    end
                    default: entry.illegal = 1'b1;
                endcase
                if (!entry.illegal) begin
                    entry.imm         = imm_i(instr);
                    entry.alu_src_imm = 1'b1;
                    entry.reg_write   = 1'b1;
                end else begin
                    entry.control = ALU_ADD;
                end
            end
            OP_LOAD: begin
                entry.illegal = 1'b0;
                unique case (funct3)
                    3'b000: entry.control = ALU_LB;
                    3'b001: entry.control = ALU_LH;
                    3'b010: entry.control = ALU_ADD;
                    3'b100: entry.control = ALU_LBU;
                    3'b101: entry.control = ALU_LHU;
                    default: entry.illegal = 1'b1;
                endcase
                if (!entry.illegal) begin
                    entry.imm         = imm_i(instr);
                    entry.alu_src_imm = 1'b1;
                    entry.reg_write   = 1'b1;
                    entry.mem_read    = 1'b1;
                end
            end
            OP_STORE: begin
                if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010) begin
                    entry.illegal     = 1'b0;
                    entry.control     = ALU_ADD;
                    entry.imm         = imm_s(instr);
                    entry.alu_src_imm = 1'b1;
                    entry.mem_write   = 1'b1;
                end
            end
            default: entry.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_decoder.sv
// RV32I decode stage: combinational decode feeding a 2-entry skid buffer with registered ready.
module alu_ctrl_decoder
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  control,
    output logic [31:0] imm,
    output logic        alu_src_imm,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        illegal,
    output logic [7:0]  illegal_count
);

    buf_state_t state;
    buf_state_t state_next;
    dec_entry_t decoded;
    dec_entry_t head;
    dec_entry_t tail;
    logic       in_ready_q;
    logic       accept;
    logic       pop;
    logic       load_head;
    logic       load_tail;
    logic       shift_up;

    rv32i_decode_comb u_decode (
        .instr (instr),
        .entry (decoded)
    );

    assign accept = in_valid && in_ready_q && !flush;
    assign pop    = (state != BUF_EMPTY) && out_ready;

    // Buffer occupancy transitions; flush wins over accept and pop
    always_comb begin
        state_next = state;
        load_head  = 1'b0;
        load_tail  = 1'b0;
        shift_up   = 1'b0;
        if (flush) begin
            state_next = BUF_EMPTY;
        end else begin
            unique case (state)
                BUF_EMPTY: begin
                    if (accept) begin
                        state_next = BUF_ONE;
                        load_head  = 1'b1;
                    end
                end
                BUF_ONE: begin
                    if (accept && pop) begin
                        load_head = 1'b1;
                    end else if (accept) begin
                        state_next = BUF_TWO;
                        load_tail  = 1'b1;
                    end else if (pop) begin
                        state_next = BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (pop) begin
                        state_next = BUF_ONE;
                        shift_up   = 1'b1;
                    end
                end
                default: state_next = BUF_EMPTY;
            endcase
        end
    end

    // State register plus a registered copy of "not full" for the fetch side
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BUF_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_next;
            in_ready_q <= (state_next != BUF_TWO);
        end
    end

    // Entry storage: head is what execute sees, tail is the skid slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (load_head) begin
                head <= decoded;
            end else if (shift_up) begin
                head <= tail;
            end
            if (load_tail) begin
                tail <= decoded;
            end
        end
    end

    // Saturating count of accepted illegal instructions, untouched by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_count <= 8'd0;
        end else if (accept && decoded.illegal && illegal_count != 8'hFF) begin
            illegal_count <= illegal_count + 8'd1;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state != BUF_EMPTY);
    assign control     = head.control;
    assign imm         = head.imm;
    assign alu_src_imm = head.alu_src_imm;
    assign reg_write   = head.reg_write;
    assign mem_read    = head.mem_read;
    assign mem_write   = head.mem_write;
    assign rs1         = head.rs1;
    assign rs2         = head.rs2;
    assign rd          = head.rd;
    assign illegal     = head.illegal;

endmodule

// File: doc/alu_ctrl_decoder.md
# alu_ctrl_decoder

Decode stage between instruction fetch and execute in the RV32I datapath. Accepts raw 32-bit instructions over a valid/ready handshake and produces the 4-bit ALU control code, immediate, register indices and memory/writeback strobes. Holds results in a 2-entry skid buffer so the fetch side sees a registered ready. Counts illegal instructions for debug.

## Interface
- No parameters; ALU code width is fixed at 4 and data width at 32.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- flush  in  1  synchronous; drop all buffered entries
- in_valid  in  1  instr valid
- in_ready  out  1  buffer can accept (registered)
- instr  in  32  raw instruction
- out_valid  out  1  decoded entry at head
- out_ready  in  1  execute stage consumes head
- control  out  4  ALU code for the ALU `control` input
- imm  out  32  sign-extended immediate
- alu_src_imm  out  1  B operand = imm
- reg_write, mem_read, mem_write  out  1 each  strobes
- rs1, rs2, rd  out  5 each  register indices
- illegal  out  1  head entry is undecodable
- illegal_count  out  8  saturating count of accepted illegal instrs

## Operation
- ALU codes: 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and, A LB, B LH, C LBU, D LHU.
- R (0110011): f3/f7 000/00→0, 000/20→1, 001/00→2, 010/00→3, 011/00→4, 100/00→5, 101/00→6, 101/20→7, 110/00→8, 111/00→9. reg_write=1. Any other f7 is illegal.
- I-ALU (0010011): f3 000→0, 010→3, 011→4, 100→5, 110→8, 111→9; 001 with f7=00→2; 101 with f7 00→6, 20→7. I-imm, alu_src_imm=1, reg_write=1.
- Load (0000011): f3 000→A, 001→B, 010→0, 100→C, 101→D; I-imm, mem_read=1, reg_write=1, alu_src_imm=1. Other f3 is illegal.
- Store (0100011): f3 000/001/010→0; S-imm, mem_write=1, alu_src_imm=1.
- Anything else is illegal. An illegal entry carries control=0 with all strobes 0, and rs1/rs2/rd still reflect the raw fields.
- Buffer states: EMPTY → ONE on accept. ONE → TWO on accept without pop. ONE → EMPTY on pop without accept. TWO → ONE on pop. Accept and pop together in ONE stays ONE.
- Order is strictly FIFO. The head entry's fields are stable while out_valid=1 and out_ready=0.
- illegal_count increments by 1 when an illegal instr is accepted and saturates at 255. Flush does not clear it.

## Timing
- Accept when in_valid and in_ready. Pop when out_valid and out_ready.
- Latency: an instruction accepted into EMPTY appears at out_valid on the next cycle.
- in_ready = (state != TWO), registered. It may drop the cycle after the second entry is accepted with no pop.
- Throughput is 1 instr/cycle when out_ready is held high.
- flush (priority over accept/pop): next cycle state=EMPTY, out_valid=0, in_ready=1. The instr presented in the flush cycle is discarded and not counted.
- Reset values: state EMPTY, in_ready=1, out_valid=0, all data outputs 0, illegal_count=0. Reset asserted mid-transfer discards everything asynchronously.

## Structure
- Shared package `rv32i_pkg` holds:
  - opcode constants: OP_R, OP_I, OP_LOAD, OP_STORE;
  - the ALU code constants ALU_ADD…ALU_LHU (values above);
  - a decoded-entry struct.
- One natural sub-module: `rv32i_decode_comb`, a pure combinational instr→entry decoder. The top holds the 2-entry buffer, the FSM and the counter.

## Test plan
- 0x002081B3 (add x3,x1,x2) → next cycle out_valid=1, control=0, rs1=1, rs2=2, rd=3, reg_write=1, alu_src_imm=0.
- 0x402081B3 (sub) → control=1; with f7=0x7F instead → illegal=1, control=0, illegal_count=1.
- 0xFFC0C283 (lbu x5,-4(x1)) → control=0xC, imm=0xFFFFFFFC, mem_read=1, rd=5.
- 0x0020A423 (sw x2,8(x1)) → control=0, imm=8, mem_write=1, reg_write=0.
- out_ready=0 with three back-to-back instrs → in_ready=0 after two accepts. Then out_ready=1 → both drain in order, in_ready returns to 1, and the third instr is then accepted.
- 300 accepted 0xFFFFFFFF → illegal_count=255. A flush with two entries buffered → out_valid=0 next cycle and the count is unchanged.
